// File: rtl/ghash_accum.sv
// ghash_accum: GHASH accumulator/controller that drives gfmul_v2 once per 128-bit block.
// Define GHASH_LEN_BLOCK_EN to append the {lenA, lenC} length block after the last data block.
module ghash_accum (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iInit,
  input  logic [127:0] iHashkey,
  input  logic [127:0] iBlock,
  input  logic         iBlock_valid,
  output logic         oBlock_ready,
  input  logic         iBlock_last,
  input  logic         iBlock_aad,
  input  logic [4:0]   iBlock_bytes,
  output logic         oMul_next,
  output logic [127:0] oMul_ctext,
  output logic [127:0] oMul_hashkey,
  output logic         oMul_valid,
  input  logic [127:0] iMul_result,
  input  logic         iMul_result_valid,
  output logic [127:0] oGhash,
  output logic         oGhash_valid
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned BYTES_W = 5;
  localparam int unsigned NBYTES  = 16;
`ifdef GHASH_LEN_BLOCK_EN
  localparam int unsigned LEN_W   = 64;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    MUL_ISSUE,
    MUL_WAIT,
`ifdef GHASH_LEN_BLOCK_EN
    LEN_ISSUE,
    LEN_WAIT,
`endif
    DONE
  } state_e;

  state_e             state_q;
  logic [BLK_W-1:0]   h_q;
  logic [BLK_W-1:0]   y_q;
  logic [BLK_W-1:0]   ctext_q;
  logic [BLK_W-1:0]   ghash_q;
  logic               last_q;
  logic               next_q;
  logic               valid_q;
  logic               ready_q;
  logic               ghash_valid_q;

  logic [BYTES_W-1:0] blk_cnt_d;
  logic [BLK_W-1:0]   masked_d;
  logic [BLK_W-1:0]   mix_d;

`ifdef GHASH_LEN_BLOCK_EN
  logic [LEN_W-1:0]   lena_q;
  logic [LEN_W-1:0]   lenc_q;
  logic [LEN_W-1:0]   blk_bits_d;
`else
  logic               unused_aad;
  assign unused_aad = iBlock_aad;
`endif

  // Valid byte count: 0 (and anything above 16) means a full block.
  always_comb begin
    blk_cnt_d = iBlock_bytes;
    if (iBlock_bytes == '0 || iBlock_bytes > BYTES_W'(NBYTES)) begin
      blk_cnt_d = BYTES_W'(NBYTES);
    end
  end

  // Byte 0 sits at the MSB end; bytes at index >= count are zeroed.
  for (genvar g = 0; g < NBYTES; g++) begin : g_mask
    assign masked_d[BLK_W-1-8*g -: 8] =
      (BYTES_W'(g) < blk_cnt_d) ? iBlock[BLK_W-1-8*g -: 8] : 8'h00;
  end

  assign mix_d = y_q ^ masked_d;

`ifdef GHASH_LEN_BLOCK_EN
  assign blk_bits_d = LEN_W'({blk_cnt_d, 3'b000});
`endif

  // Controller: init/abort has priority over everything except reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= IDLE;
      h_q           <= '0;
      y_q           <= '0;
      ctext_q       <= '0;
      ghash_q       <= '0;
      last_q        <= 1'b0;
      next_q        <= 1'b0;
      valid_q       <= 1'b0;
      ready_q       <= 1'b0;
      ghash_valid_q <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
      lena_q        <= '0;
      lenc_q        <= '0;
`endif
    end else if (iInit) begin
      state_q       <= WAIT_BLK;
      h_q           <= iHashkey;
      y_q           <= '0;
      last_q        <= 1'b0;
      next_q        <= 1'b0;
      valid_q       <= 1'b0;
      ready_q       <= 1'b1;
      ghash_valid_q <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
      lena_q        <= '0;
      lenc_q        <= '0;
`endif
    end else begin
      next_q        <= 1'b0;
      ghash_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
        WAIT_BLK: begin
          if (iBlock_valid) begin
            ctext_q <= mix_d;
            last_q  <= iBlock_last;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            next_q  <= 1'b1;
            state_q <= MUL_ISSUE;
`ifdef GHASH_LEN_BLOCK_EN
            if (iBlock_aad) begin
              lena_q <= lena_q + blk_bits_d;
            end else begin
              lenc_q <= lenc_q + blk_bits_d;
            end
`endif
          end
        end
        MUL_ISSUE: begin
          state_q <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (iMul_result_valid) begin
            y_q <= iMul_result;
            if (last_q) begin
`ifdef GHASH_LEN_BLOCK_EN
              ctext_q <= iMul_result ^ {lena_q, lenc_q};
              next_q  <= 1'b1;
              state_q <= LEN_ISSUE;
`else
              ghash_q       <= iMul_result;
              ghash_valid_q <= 1'b1;
              valid_q       <= 1'b0;
              state_q       <= DONE;
`endif
            end else begin
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= WAIT_BLK;
            end
          end
        end
`ifdef GHASH_LEN_BLOCK_EN
        LEN_ISSUE: begin
          state_q <= LEN_WAIT;
        end
        LEN_WAIT: begin
          if (iMul_result_valid) begin
            y_q           <= iMul_result;
            ghash_q       <= iMul_result;
            ghash_valid_q <= 1'b1;
            valid_q       <= 1'b0;
            state_q       <= DONE;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oBlock_ready = ready_q;
  assign oMul_next    = next_q;
  assign oMul_ctext   = ctext_q;
  assign oMul_hashkey = h_q;
  assign oMul_valid   = valid_q;
  assign oGhash       = ghash_q;
  assign oGhash_valid = ghash_valid_q;

endmodule

// File: tb/tb_ghash_accum.sv
// tb_ghash_accum: scoreboard bench for ghash_accum with a behavioural GF(2^128) multiplier.
// Follows GHASH_LEN_BLOCK_EN the same way the design does.
module tb_ghash_accum;

  localparam logic [127:0] H1 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] B1 = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [127:0] G1 = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [127:0] H2 = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [127:0] A2 = 128'hD609B1F056637A0D46DF998D88E52E00;
  localparam logic [127:0] B2 = 128'hB2C2846512153524C0895E81FFFFFFFF;
  localparam logic [127:0] G2 = 128'hB99ABF6BDBD18B8E148F8030F0686F28;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iInit;
  logic [127:0] iHashkey;
  logic [127:0] iBlock;
  logic         iBlock_valid;
  logic         oBlock_ready;
  logic         iBlock_last;
  logic         iBlock_aad;
  logic [4:0]   iBlock_bytes;
  logic         oMul_next;
  logic [127:0] oMul_ctext;
  logic [127:0] oMul_hashkey;
  logic         oMul_valid;
  logic [127:0] iMul_result;
  logic         iMul_result_valid;
  logic [127:0] oGhash;
  logic         oGhash_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int next_cnt = 0;
  int ready_cnt = 0;
  int n_aad    = 0;

  logic [127:0] exp_ctext_q[$];
  logic [127:0] exp_ghash_q[$];
  logic [127:0] h_m, y_m, last_ctext, mon_e;
  logic [63:0]  lena_m, lenc_m;

  ghash_accum dut (
    .iClk(iClk), .iRst(iRst), .iInit(iInit), .iHashkey(iHashkey),
    .iBlock(iBlock), .iBlock_valid(iBlock_valid), .oBlock_ready(oBlock_ready),
    .iBlock_last(iBlock_last), .iBlock_aad(iBlock_aad), .iBlock_bytes(iBlock_bytes),
    .oMul_next(oMul_next), .oMul_ctext(oMul_ctext), .oMul_hashkey(oMul_hashkey),
    .oMul_valid(oMul_valid), .iMul_result(iMul_result),
    .iMul_result_valid(iMul_result_valid), .oGhash(oGhash), .oGhash_valid(oGhash_valid)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // GCM-convention multiply: bit 0 of the field element is the vector MSB.
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] mask_blk(input logic [127:0] blk, input int cnt);
    logic [127:0] m;
    m = blk;
    for (int i = 0; i < 16; i++) begin
      if (i >= cnt) m[127-8*i -: 8] = 8'h00;
    end
    return m;
  endfunction

  task automatic model_init(input logic [127:0] h);
    h_m    = h;
    y_m    = '0;
    lena_m = '0;
    lenc_m = '0;
  endtask

  task automatic model_push(input logic [127:0] blk, input logic [4:0] n, input bit last, input bit aad);
    logic [127:0] x;
    int cnt;
    cnt = (n == 5'd0 || n > 5'd16) ? 16 : int'(n);
    x = y_m ^ mask_blk(blk, cnt);
    exp_ctext_q.push_back(x);
    y_m = gf_mult(x, h_m);
    if (aad) n_aad++;
`ifdef GHASH_LEN_BLOCK_EN
    if (aad) lena_m = lena_m + 64'(8 * cnt);
    else     lenc_m = lenc_m + 64'(8 * cnt);
    if (last) begin
      x = y_m ^ {lena_m, lenc_m};
      exp_ctext_q.push_back(x);
      y_m = gf_mult(x, h_m);
    end
`endif
    if (last) exp_ghash_q.push_back(y_m);
  endtask

  // Output monitor: pops the scoreboard whenever the DUT issues or finishes.
  always @(negedge iClk) begin
    if (!iRst) begin
      if (oBlock_ready) ready_cnt++;
      if (oMul_next) begin
        next_cnt++;
        last_ctext = oMul_ctext;
        if (exp_ctext_q.size() == 0) chk("mul_next_unexpected", 128'(1), 128'(0));
        else begin
          mon_e = exp_ctext_q.pop_front();
          chk("mul_ctext", oMul_ctext, mon_e);
          chk("mul_hashkey", oMul_hashkey, h_m);
        end
      end
      if (oGhash_valid) begin
        if (exp_ghash_q.size() == 0) chk("ghash_unexpected", 128'(1), 128'(0));
        else begin
          mon_e = exp_ghash_q.pop_front();
          chk("ghash", oGhash, mon_e);
        end
      end
    end
  end

  task automatic do_init(input logic [127:0] h);
    iInit    = 1'b1;
    iHashkey = h;
    model_init(h);
    @(negedge iClk);
    iInit = 1'b0;
  endtask

  task automatic wait_next();
    int t = 0;
    while (!oMul_next && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (!oMul_next) chk("mul_next_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] blk, input logic [4:0] n, input bit last, input bit aad);
    int t = 0;
    while (!oBlock_ready && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (!oBlock_ready) begin
      chk("ready_timeout", 128'(0), 128'(1));
      return;
    end
    model_push(blk, n, last, aad);
    iBlock       = blk;
    iBlock_bytes = n;
    iBlock_last  = last;
    iBlock_aad   = aad;
    iBlock_valid = 1'b1;
    @(negedge iClk);
    iBlock_valid = 1'b0;
    chk("accept_next", 128'(oMul_next), 128'(1));
    chk("accept_valid", 128'(oMul_valid), 128'(1));
    chk("accept_ready", 128'(oBlock_ready), 128'(0));
  endtask

  // mode 0: more data follows, 1: last data block, 2: length block
  task automatic mul_respond(input int lat, input int mode);
    logic [127:0] res;
    wait_next();
    res = gf_mult(oMul_ctext, oMul_hashkey);
    repeat (lat) @(negedge iClk);
    chk("mul_valid_hold", 128'(oMul_valid), 128'(1));
    iMul_result       = res;
    iMul_result_valid = 1'b1;
    @(negedge iClk);
    iMul_result_valid = 1'b0;
    if (mode == 0) chk("res_to_ready", 128'(oBlock_ready), 128'(1));
`ifdef GHASH_LEN_BLOCK_EN
    else if (mode == 1) chk("res_to_len_next", 128'(oMul_next), 128'(1));
`endif
    else chk("res_to_ghash_valid", 128'(oGhash_valid), 128'(1));
  endtask

  task automatic finish_msg(input int lat);
`ifdef GHASH_LEN_BLOCK_EN
    mul_respond(lat, 2);
`else
    if (lat < 0) chk("neg_latency", 128'(lat), 128'(0));
`endif
    @(negedge iClk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [127:0] rb;
    iRst = 1'b1; iInit = 1'b0; iHashkey = '0; iBlock = '0; iBlock_valid = 1'b0;
    iBlock_last = 1'b0; iBlock_aad = 1'b0; iBlock_bytes = '0;
    iMul_result = '0; iMul_result_valid = 1'b0;
    model_init('0);
    repeat (3) @(negedge iClk);
    chk("rst_ready", 128'(oBlock_ready), 128'(0));
    chk("rst_next", 128'(oMul_next), 128'(0));
    chk("rst_mul_valid", 128'(oMul_valid), 128'(0));
    chk("rst_ghash_valid", 128'(oGhash_valid), 128'(0));
    chk("rst_ctext", oMul_ctext, '0);
    chk("rst_hashkey", oMul_hashkey, '0);
    chk("rst_ghash", oGhash, '0);
    iRst = 1'b0;
    @(negedge iClk);

    // Single full block against the known answer.
    do_init(H1);
    send_block(B1, 5'd16, 1'b1, 1'b0);
    mul_respond(1, 1);
    finish_msg(1);
`ifndef GHASH_LEN_BLOCK_EN
    chk("kat_single", oGhash, G1);
`endif

    // Full AAD block followed by a 12-byte block.
    do_init(H2);
    send_block(A2, 5'd16, 1'b0, 1'b1);
    mul_respond(2, 0);
    send_block(B2, 5'd12, 1'b1, 1'b1);
    mul_respond(3, 1);
    finish_msg(1);
`ifdef GHASH_LEN_BLOCK_EN
    chk("kat_len_ctext", last_ctext, G2 ^ {64'hE0, 64'h0});
`else
    chk("kat_partial", oGhash, G2);
`endif

    // Random messages, byte counts include 0 (full block).
    for (int m = 0; m < 4; m++) begin
      do_init({$urandom, $urandom, $urandom, $urandom});
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        rb = {$urandom, $urandom, $urandom, $urandom};
        send_block(rb, 5'($urandom_range(0, 16)), b == nb - 1, 1'($urandom_range(0, 1)));
        mul_respond($urandom_range(1, 4), (b == nb - 1) ? 1 : 0);
      end
      finish_msg($urandom_range(1, 3));
    end

    // iInit and iBlock_valid in the same cycle: init wins.
    do_init(H2);
    iInit = 1'b1; iHashkey = H1; model_init(H1);
    iBlock = B2; iBlock_bytes = 5'd16; iBlock_valid = 1'b1;
    @(negedge iClk);
    iInit = 1'b0; iBlock_valid = 1'b0;
    chk("init_wins_next", 128'(oMul_next), 128'(0));
    chk("init_wins_ready", 128'(oBlock_ready), 128'(1));
    chk("init_wins_hashkey", oMul_hashkey, H1);

    // Abort during MUL_WAIT, then a stray late result.
    send_block(B2, 5'd16, 1'b1, 1'b0);
    @(negedge iClk);
    iInit = 1'b1; iHashkey = H1; model_init(H1);
    @(negedge iClk);
    iInit = 1'b0;
    exp_ctext_q.delete();
    exp_ghash_q.delete();
    chk("abort_mul_valid", 128'(oMul_valid), 128'(0));
    chk("abort_ready", 128'(oBlock_ready), 128'(1));
    iMul_result = {$urandom, $urandom, $urandom, $urandom};
    iMul_result_valid = 1'b1;
    @(negedge iClk);
    iMul_result_valid = 1'b0;
    chk("late_res_ready", 128'(oBlock_ready), 128'(1));
    chk("late_res_ghash_valid", 128'(oGhash_valid), 128'(0));
    send_block(B1, 5'd16, 1'b1, 1'b0);
    mul_respond(2, 1);
    finish_msg(1);
`ifndef GHASH_LEN_BLOCK_EN
    chk("kat_after_abort", oGhash, G1);
`endif

    // Backpressure: iBlock_valid held high across the multiply.
    begin
      int nc0, rc0;
      nc0 = next_cnt;
      rc0 = ready_cnt;
      iInit = 1'b1; iHashkey = H2; model_init(H2);
      model_push(A2, 5'd16, 1'b0, 1'b1);
      iBlock = A2; iBlock_bytes = 5'd16; iBlock_last = 1'b0; iBlock_aad = 1'b1;
      @(negedge iClk);
      iInit = 1'b0;
      iBlock_valid = 1'b1;
      wait_next();
      model_push(B2, 5'd12, 1'b1, 1'b1);
      iBlock = B2; iBlock_bytes = 5'd12; iBlock_last = 1'b1;
      mul_respond(3, 0);
      wait_next();
      iBlock_valid = 1'b0;
      mul_respond(1, 1);
      finish_msg(1);
      repeat (3) @(negedge iClk);
`ifdef GHASH_LEN_BLOCK_EN
      chk("bp_next_count", 128'(next_cnt - nc0), 128'(3));
`else
      chk("bp_next_count", 128'(next_cnt - nc0), 128'(2));
      chk("bp_ghash", oGhash, G2);
`endif
      chk("bp_ready_count", 128'(ready_cnt - rc0), 128'(2));
    end

    // Reset in MUL_WAIT; a following result must be ignored.
    do_init(H1);
    send_block(B1, 5'd16, 1'b1, 1'b0);
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    exp_ctext_q.delete();
    exp_ghash_q.delete();
    chk("mid_rst_ready", 128'(oBlock_ready), 128'(0));
    chk("mid_rst_next", 128'(oMul_next), 128'(0));
    chk("mid_rst_mul_valid", 128'(oMul_valid), 128'(0));
    chk("mid_rst_ctext", oMul_ctext, '0);
    chk("mid_rst_hashkey", oMul_hashkey, '0);
    chk("mid_rst_ghash", oGhash, '0);
    iRst = 1'b0;
    iMul_result = G1;
    iMul_result_valid = 1'b1;
    @(negedge iClk);
    iMul_result_valid = 1'b0;
    @(negedge iClk);
    chk("post_rst_ghash_valid", 128'(oGhash_valid), 128'(0));
    chk("post_rst_mul_valid", 128'(oMul_valid), 128'(0));
    chk("post_rst_ghash", oGhash, '0);

    repeat (3) @(negedge iClk);
    chk("ctext_q_left", 128'(exp_ctext_q.size()), 128'(0));
    chk("ghash_q_left", 128'(exp_ghash_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
